// File: rtl/imm_extend_stage.sv
// Immediate extension stage: sign/zero/upper/branch widening of an instruction
// immediate, registered behind a valid/ready handshake with a two-entry skid buffer.
module imm_extend_stage #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  if (IN_W < 2 || IN_W > OUT_W || BR_SHIFT >= OUT_W) begin : g_param_err
    initial $error("imm_extend_stage: illegal parameters IN_W=%0d OUT_W=%0d BR_SHIFT=%0d",
                   IN_W, OUT_W, BR_SHIFT);
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [OUT_W-1:0]   zext;
  logic [OUT_W-1:0]   sext;
  logic [OUT_W-1:0]   ext_data;
  logic [OUT_W-1:0]   skid_data;
  logic [TAG_W-1:0]   skid_tag;
  logic               accept;
  logic               load_out_in;
  logic               load_out_skid;
  logic               load_skid;

  // Combinational extension of the incoming immediate
  always_comb begin
    zext     = OUT_W'(in_imm);
    sext     = OUT_W'($signed(in_imm));
    ext_data = sext;
    case (in_mode)
      2'd0: ext_data = sext;
      2'd1: ext_data = zext;
      2'd2: ext_data = zext << PAD_W;
      2'd3: ext_data = sext << BR_SHIFT;
      default: ext_data = sext;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Occupancy next-state and datapath load selects
  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next  = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_next    = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State and handshake flags; in_ready is a flop so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next != FULL);
      out_valid <= (state_next != EMPTY);
    end
  end

  // Output and skid registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      if (load_out_in) begin
        out_data <= ext_data;
        out_tag  <= in_tag;
      end else if (load_out_skid) begin
        out_data <= skid_data;
        out_tag  <= skid_tag;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_tag  <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: vector tables, backpressure/reset
// sequences and a randomised scoreboard run.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        p_in_valid;
  logic        p_in_ready;
  logic [11:0] p_in_imm;
  logic [1:0]  p_in_mode;
  logic [4:0]  p_in_tag;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [19:0] p_out_data;
  logic [4:0]  p_out_tag;

  always #5 clk = ~clk;

  imm_extend_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_stage #(.IN_W(12), .OUT_W(20), .BR_SHIFT(1), .TAG_W(5)) dut_p (
    .clk(clk), .reset(reset),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm), .in_mode(p_in_mode),
    .in_tag(p_in_tag), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .out_tag(p_out_tag)
  );

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } sb_t;

  vec_t tbl[8];
  vec_t ptbl[3];
  sb_t  sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic sb_en = 1'b0;
  logic rand_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] s;
    s = {{16{imm[15]}}, imm};
    case (mode)
      2'd0: return s;
      2'd1: return {16'h0000, imm};
      2'd2: return {imm, 16'h0000};
      default: return {s[29:0], 2'b00};
    endcase
  endfunction

  // Hold an entry on the input until accepted; caller sits just after a rising edge
  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    logic acc;
    int   budget;
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
    acc = 1'b0; budget = 0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  // Scoreboard and stable-output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, prev_data);
        check("hold_tag", 32'(out_tag), 32'(prev_tag));
      end
      if (sb_en && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_output", 32'(sbq.size()), 32'd1);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      if (sb_en && in_valid && in_ready) sbq.push_back('{model(in_imm, in_mode), in_tag});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  initial begin
    tbl[0] = '{16'h0001, 2'd0, 5'd1, 32'h00000001};
    tbl[1] = '{16'h7FFF, 2'd0, 5'd2, 32'h00007FFF};
    tbl[2] = '{16'h8000, 2'd0, 5'd3, 32'hFFFF8000};
    tbl[3] = '{16'hAAFA, 2'd0, 5'd4, 32'hFFFFAAFA};
    tbl[4] = '{16'hAAFA, 2'd1, 5'd5, 32'h0000AAFA};
    tbl[5] = '{16'hAAFA, 2'd2, 5'd6, 32'hAAFA0000};
    tbl[6] = '{16'hAAFA, 2'd3, 5'd7, 32'hFFFEABE8};
    tbl[7] = '{16'h8000, 2'd3, 5'd31, 32'hFFFE0000};
    ptbl[0] = '{16'h0800, 2'd0, 5'd9,  32'h000FF800};
    ptbl[1] = '{16'h0800, 2'd2, 5'd10, 32'h00080000};
    ptbl[2] = '{16'h0800, 2'd3, 5'd11, 32'h000FF000};

    reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_imm = '0; p_in_mode = '0; p_in_tag = '0; p_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;

    // Back-to-back vectors, result visible one cycle after acceptance
    for (int i = 0; i < 8; i++) begin
      check("tbl_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_imm = tbl[i].imm; in_mode = tbl[i].mode; in_tag = tbl[i].tag;
      @(posedge clk);
      #1;
      check("tbl_out_valid", 32'(out_valid), 32'd1);
      check("tbl_out_data", out_data, tbl[i].exp);
      check("tbl_out_tag", 32'(out_tag), 32'(tbl[i].tag));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("tbl_drained", 32'(out_valid), 32'd0);

    for (int i = 0; i < 3; i++) begin
      p_in_valid = 1'b1; p_in_imm = 12'(ptbl[i].imm); p_in_mode = ptbl[i].mode; p_in_tag = ptbl[i].tag;
      @(posedge clk);
      #1;
      check("par_out_valid", 32'(p_out_valid), 32'd1);
      check("par_out_data", 32'(p_out_data), ptbl[i].exp);
      check("par_out_tag", 32'(p_out_tag), 32'(ptbl[i].tag));
    end
    p_in_valid = 1'b0;

    // Backpressure: three offers with out_ready low, then release
    sb_en = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'd1; in_mode = 2'd1; in_tag = 5'd1;
    @(posedge clk); #1;
    in_imm = 16'd2; in_tag = 5'd2;
    @(posedge clk); #1;
    in_imm = 16'd3; in_tag = 5'd3;
    repeat (2) begin @(posedge clk); #1; end
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_tag_hold", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_skid_tag", 32'(out_tag), 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_third_tag", 32'(out_tag), 32'd3);
    @(posedge clk); #1;
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset while FULL, with an offer present during reset
    out_ready = 1'b0;
    send(16'h0011, 2'd1, 5'd10);
    send(16'h0022, 2'd1, 5'd11);
    check("rf_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    in_valid = 1'b1; in_imm = 16'hDEAD; in_mode = 2'd0; in_tag = 5'd21;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    check("rf_out_valid", 32'(out_valid), 32'd0);
    check("rf_in_ready", 32'(in_ready), 32'd1);
    check("rf_out_data", out_data, 32'd0);
    check("rf_out_tag", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    send(16'h0005, 2'd0, 5'd7);
    check("rf_new_valid", 32'(out_valid), 32'd1);
    check("rf_new_data", out_data, 32'h00000005);
    check("rf_new_tag", 32'(out_tag), 32'd7);
    @(posedge clk); #1;
    check("rf_alone", 32'(out_valid), 32'd0);

    // Randomised valid/out_ready traffic against the scoreboard
    rand_en = 1'b1;
    fork
      begin
        while (rand_en) begin
          @(posedge clk);
          #1;
          if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 4000; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(16'($urandom), 2'($urandom_range(0, 3)), 5'($urandom));
    end
    rand_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (sbq.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    check("rnd_sb_drained", 32'(sbq.size()), 32'd0);
    check("rnd_out_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
